// File: rtl/oak_pkg.sv
// oak_pkg: shared widths, opcodes and frame field helpers for the oak core front end
package oak_pkg;

    localparam int FRAME_W    = 17;
    localparam int PC_W       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int OP_W       = 4;
    localparam int OPND_W     = FRAME_W - OP_W;

    localparam logic [FRAME_W-1:0] NOP_FRAME = '0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_SHL = 4'h7,
        OP_SHR = 4'h8,
        OP_LD  = 4'h9,
        OP_ST  = 4'hA,
        OP_CMP = 4'hB,
        OP_JMP = 4'hC,
        OP_JEQ = 4'hD,
        OP_JNE = 4'hE,
        OP_NOT = 4'hF
    } opcode_t;

    function automatic opcode_t frame_op(input logic [FRAME_W-1:0] f);
        return opcode_t'(f[FRAME_W-1 -: OP_W]);
    endfunction

    function automatic logic [OPND_W-1:0] frame_operand(input logic [FRAME_W-1:0] f);
        return f[OPND_W-1:0];
    endfunction

endpackage

// File: rtl/oak_frame_fifo.sv
// oak_frame_fifo: small synchronous FIFO carrying a frame and its fetch address
module oak_frame_fifo #(
    parameter int DW    = 17,
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [DW-1:0]            i_data,
    input  logic [AW-1:0]            i_pc,
    output logic [DW-1:0]            o_data,
    output logic [AW-1:0]            o_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_data [DEPTH];
    logic [AW-1:0] r_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == (PW+1)'(DEPTH);
    assign o_count = r_count;
    assign o_data  = r_data[r_rd_ptr];
    assign o_pc    = r_pc[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // storage write; entries need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_data[r_wr_ptr] <= i_data;
            r_pc[r_wr_ptr]   <= i_pc;
        end
    end

    // pointers and occupancy; flush overrides any push or pop in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/oak_frame_fetch.sv
// oak_frame_fetch: program memory, fetch PC and prefetch FIFO feeding the oak core
module oak_frame_fetch
    import oak_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [FRAME_W-1:0] prog_wdata,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [PC_W-1:0]    frame_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [FRAME_W-1:0] r_mem [2**PC_W];
    logic [FRAME_W-1:0] r_rd_data;
    logic [PC_W-1:0]    r_rd_pc;
    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_inflight;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_occ;
    logic               w_full;
    logic               w_empty;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [FRAME_W-1:0] w_head;
    logic [PC_W-1:0]    w_head_pc;

    // an in-flight read already owns a FIFO slot, so it counts toward occupancy
    assign w_occ       = w_count + CNT_W'(r_inflight);
    assign w_issue     = run && !redirect && !w_full && (w_occ < CNT_W'(DEPTH));
    assign w_push      = r_inflight && !redirect;
    assign w_pop       = frame_valid && frame_ready;
    assign frame_valid = !w_empty;
    assign frame       = frame_valid ? w_head : NOP_FRAME;
    assign frame_pc    = frame_valid ? w_head_pc : '0;

    // program memory: loads only while halted, one-cycle registered read on issue
    always_ff @(posedge sysclk) begin
        if (prog_we && !run)
            r_mem[prog_addr] <= prog_wdata;
        if (w_issue)
            r_rd_data <= r_mem[r_fetch_pc];
    end

    // fetch PC and in-flight tracking; a redirect drops the outstanding read
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= '0;
            r_rd_pc    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue)
                r_rd_pc <= r_fetch_pc;
            r_fetch_pc <= redirect ? redirect_pc : w_issue ? r_fetch_pc + 1'b1 : r_fetch_pc;
        end
    end

    oak_frame_fifo #(
        .DW    (FRAME_W),
        .AW    (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (sysclk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (r_rd_data),
        .i_pc    (r_rd_pc),
        .o_data  (w_head),
        .o_pc    (w_head_pc),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
